// File: rtl/gan_layer_sequencer_pkg.sv
// gan_ctrl_pkg: shared state encoding and default sizing for the generator/discriminator sequencers
package gan_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_DRAIN, S_ERR} state_t;
  localparam int DEF_NUM_LAYERS = 4;
  localparam int DEF_TIMEOUT_CYCLES = 20000;
  localparam int DEF_TO_W = 16;
  localparam int DEF_CNT_W = 24;
  localparam int IDX_W = 3;
endpackage

// File: rtl/gan_layer_sequencer_watchdog.sv
// seq_timeout_watchdog: counts enabled cycles since clear and flags the TIMEOUT_CYCLES-th one
module seq_timeout_watchdog #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int TO_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  assign expired = enable && cnt == TO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/gan_layer_sequencer.sv
// gan_layer_sequencer: starts each MAC layer in turn per latent request, with timeout, abort and frame cycle accounting
module gan_layer_sequencer
  import gan_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W = DEF_TO_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  input  logic                  abort,
  output logic                  busy,
  output logic [IDX_W-1:0]      active_layer,
  output logic                  error,
  output logic [IDX_W-1:0]      error_layer,
  output logic [CNT_W-1:0]      frame_cycles
);
  state_t state;
  logic [CNT_W-1:0] fcnt, fsat;
  logic [NUM_LAYERS-1:0] cur;
  logic done_act, last, expired;
  assign req_ready = state == S_IDLE;
  assign cur = NUM_LAYERS'(1) << active_layer;
  assign done_act = |(layer_done & cur);
  assign last = active_layer == IDX_W'(NUM_LAYERS - 1);
  assign fsat = (&fcnt) ? fcnt : fcnt + 1'b1;
  seq_timeout_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_wd (
    .clk,
    .rst_n,
    .clear(state == S_START),
    .enable(state == S_WAIT || state == S_DRAIN),
    .expired
  );
  // frame_cycles latches fsat on the final WAIT cycle so that cycle is counted too
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      layer_start <= '0;
      resp_valid <= 1'b0;
      busy <= 1'b0;
      active_layer <= '0;
      error <= 1'b0;
      error_layer <= '0;
      frame_cycles <= '0;
      fcnt <= '0;
    end else begin
      layer_start <= '0;
      if (state == S_START || state == S_WAIT) fcnt <= fsat;
      case (state)
        S_IDLE: if (req_valid) begin
          state <= S_START;
          layer_start <= NUM_LAYERS'(1);
          busy <= 1'b1;
          active_layer <= '0;
          fcnt <= '0;
          error <= 1'b0;
        end
        S_START: state <= abort ? S_DRAIN : S_WAIT;
        S_WAIT: if (abort) begin
          state <= done_act ? S_IDLE : S_DRAIN;
          busy <= !done_act;
        end else if (done_act && last) begin
          state <= S_RESP;
          resp_valid <= 1'b1;
          frame_cycles <= fsat;
        end else if (done_act) begin
          state <= S_START;
          active_layer <= active_layer + 1'b1;
          layer_start <= cur << 1;
        end else if (expired) begin
          state <= S_ERR;
          busy <= 1'b0;
          error <= 1'b1;
          error_layer <= active_layer;
        end
        S_DRAIN: if (done_act || expired) begin
          state <= S_IDLE;
          busy <= 1'b0;
          if (!done_act) begin
            error <= 1'b1;
            error_layer <= active_layer;
          end
        end
        S_RESP: if (resp_ready || abort) begin
          state <= S_IDLE;
          resp_valid <= 1'b0;
          busy <= 1'b0;
        end
        S_ERR: if (abort) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_gan_layer_sequencer.sv
// tb_gan_layer_sequencer: randomized and directed frames against a schedule-based reference model
module tb_gan_layer_sequencer;
  localparam int NL = 3;
  localparam int TO = 100;
  localparam int CW = 24;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, resp_ready = 1'b0, abort = 1'b0;
  logic req_ready, resp_valid, busy, error;
  logic [NL-1:0] layer_start, layer_done = '0, spur = '0, hang = '0;
  logic [2:0] active_layer, error_layer;
  logic [CW-1:0] frame_cycles;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int lat[NL];
  int due[NL];
  always #5 clk = ~clk;
  gan_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .TO_W(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .layer_start(layer_start), .layer_done(layer_done), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .abort(abort), .busy(busy), .active_layer(active_layer),
    .error(error), .error_layer(error_layer), .frame_cycles(frame_cycles)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  // stub layers: done is driven lat+1 cycles after the cycle in which start is seen
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NL; k++) begin
      if (layer_start[k] && !hang[k]) due[k] = cyc + lat[k] + 1;
      layer_done[k] = (due[k] == cyc) | spur[k];
    end
  endtask
  task automatic clear_stub();
    for (int k = 0; k < NL; k++) due[k] = -1;
    spur = '0;
    hang = '0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, layer_start, 0);
  endtask
  task automatic run_frame(input int l0, input int l1, input int l2, input int hold,
                           input int spur_off, input int spur_bit);
    int t[NL];
    int rt, fc, idx;
    logic [NL-1:0] exp_start;
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1;
    t[0] = cyc + 1;
    fc = 0;
    for (int k = 0; k < NL; k++) begin
      if (k > 0) t[k] = t[k-1] + lat[k-1] + 2;
      fc += lat[k] + 2;
    end
    rt = t[NL-1] + lat[NL-1] + 2;
    while (cyc < rt) begin
      spur = (spur_off >= 0 && cyc + 1 == t[0] + spur_off) ? NL'(1) << spur_bit : '0;
      step();
      req_valid = 1'($urandom_range(0, 1));
      idx = 0;
      exp_start = '0;
      for (int k = 0; k < NL; k++) begin
        if (cyc >= t[k]) idx = k;
        if (cyc == t[k]) exp_start = NL'(1) << k;
      end
      check("start", layer_start, exp_start);
      check("resp_valid", resp_valid, 32'(cyc == rt));
      check("busy", busy, 1);
      check("req_ready_busy", req_ready, 0);
      check("active_layer", active_layer, idx);
      if (cyc == t[0]) check("error_cleared", error, 0);
    end
    spur = '0;
    check("frame_cycles", frame_cycles, fc);
    repeat (hold) begin
      req_valid = 1'b1;
      step();
      check("resp_hold", resp_valid, 1);
      check("hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
    check_idle("post_frame");
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int s, sd, l0, off;
    clear_stub();
    for (int k = 0; k < NL; k++) lat[k] = 0;
    repeat (3) step();
    check("rst_ready", req_ready, 1);
    check("rst_resp", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start", layer_start, 0);
    check("rst_error", error, 0);
    check("rst_frame_cycles", frame_cycles, 0);
    rst_n = 1'b1;
    step();
    run_frame(10, 20, 5, 7, -1, 0);
    check("frame_cycles_41", frame_cycles, 41);
    // layer 1 never finishes
    clear_stub();
    hang[1] = 1'b1;
    lat[0] = 10;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 200 && !layer_start[1]; i++) step();
    check("to_start1", layer_start[1], 1);
    repeat (TO) begin
      step();
      check("to_no_err_yet", error, 0);
    end
    step();
    check("to_error", error, 1);
    check("to_error_layer", error_layer, 1);
    check("to_busy", busy, 0);
    check("to_ready", req_ready, 0);
    req_valid = 1'b1;
    repeat (3) begin
      step();
      check("err_ready", req_ready, 0);
      check("err_sticky", error, 1);
    end
    req_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("err_abort");
    check("err_kept", error, 1);
    hang = '0;
    run_frame(3, 4, 2, 1, -1, 0);
    check("err_cleared", error, 0);
    // abort while layer 0 runs
    clear_stub();
    lat[0] = 10;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    s = cyc;
    sd = s + lat[0] + 1;
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    while (cyc < sd) begin
      step();
      check("drain_busy", busy, 1);
      check("drain_ready", req_ready, 0);
      check("drain_nostart", layer_start, 0);
    end
    step();
    check_idle("drain_done");
    repeat (5) begin
      step();
      check("drain_nostart_after", layer_start, 0);
    end
    // spurious done on an idle layer, and done[0] in the start cycle
    clear_stub();
    run_frame(8, 6, 4, 0, 3, 2);
    run_frame(8, 6, 4, 2, 0, 0);
    // abort together with done[0]
    clear_stub();
    lat[0] = 6;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    sd = cyc + lat[0] + 1;
    while (cyc < sd) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort_done");
    repeat (25) begin
      step();
      check("abort_done_nostart", layer_start, 0);
    end
    // asynchronous reset in the middle of layer 1
    clear_stub();
    lat[0] = 5; lat[1] = 30; lat[2] = 5;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 100 && !layer_start[1]; i++) step();
    check("rst_mid_start1", layer_start[1], 1);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_active", active_layer, 0);
    check("mid_rst_frame", frame_cycles, 0);
    check("mid_rst_error_layer", error_layer, 0);
    check("mid_rst_resp", resp_valid, 0);
    check("mid_rst_ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    clear_stub();
    step();
    run_frame(7, 9, 11, 1, -1, 0);
    repeat (12) begin
      l0 = $urandom_range(1, 40);
      off = $urandom_range(0, l0);
      run_frame(l0, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 4),
                off, off == 0 ? $urandom_range(0, NL - 1) : $urandom_range(1, NL - 1));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
